// File: rtl/sram_port_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | sram_port_arbiter_if                                                     |
// | CPU-side request/grant/read-return bundle for the two SRAM masters.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sram_port_arbiter_if;
  logic [1:0]  m_req;
  logic [1:0]  m_we;
  logic [13:0] m0_addr;
  logic [13:0] m1_addr;
  logic [31:0] m0_bweb;
  logic [31:0] m1_bweb;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;

  modport master (
    output m_req, m_we, m0_addr, m1_addr, m0_bweb, m1_bweb, m0_wdata, m1_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_we, m0_addr, m1_addr, m0_bweb, m1_bweb, m0_wdata, m1_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

`default_nettype wire

// File: rtl/sram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | sram_port_arbiter                                                        |
// | Round-robin, burst-bounded arbiter sharing one SRAM between M0 and M1.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sram_port_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sram_port_arbiter_if.slave bus,
  output logic               sram_ceb,
  output logic               sram_web,
  output logic [31:0]        sram_bweb,
  output logic [13:0]        sram_a,
  output logic [31:0]        sram_di,
  input  wire logic [31:0]   sram_do
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [3:0] C_MAX  = 4'(MAX_BURST);

  logic [1:0] r_state;
  logic [3:0] r_burst_cnt;
  logic       r_last_gnt;
  logic       r_rd_pend;
  logic       r_rd_id;

  logic [1:0] w_state_nxt;
  logic [3:0] w_cnt_nxt;
  logic       w_last_nxt;
  logic       w_win_vld;
  logic       w_win;
  logic       w_same_owner;
  logic       w_win_we;
  logic       w_go;

  // Winner selection and next-state
  always_comb begin
    w_win_vld = 1'b0;
    w_win     = 1'b0;
    case (r_state)
      S_OWN0: begin
        if (bus.m_req[0] && (r_burst_cnt < C_MAX || !bus.m_req[1])) begin
          w_win_vld = 1'b1;
          w_win     = 1'b0;
        end else if (bus.m_req[1]) begin
          w_win_vld = 1'b1;
          w_win     = 1'b1;
        end
      end
      S_OWN1: begin
        if (bus.m_req[1] && (r_burst_cnt < C_MAX || !bus.m_req[0])) begin
          w_win_vld = 1'b1;
          w_win     = 1'b1;
        end else if (bus.m_req[0]) begin
          w_win_vld = 1'b1;
          w_win     = 1'b0;
        end
      end
      default: begin
        if (&bus.m_req) begin
          w_win_vld = 1'b1;
          w_win     = ~r_last_gnt;
        end else if (bus.m_req[0]) begin
          w_win_vld = 1'b1;
          w_win     = 1'b0;
        end else if (bus.m_req[1]) begin
          w_win_vld = 1'b1;
          w_win     = 1'b1;
        end
      end
    endcase

    w_same_owner = (r_state == S_OWN0 && !w_win) || (r_state == S_OWN1 && w_win);
    w_state_nxt  = S_IDLE;
    w_cnt_nxt    = 4'd0;
    w_last_nxt   = r_last_gnt;
    if (w_win_vld) begin
      w_state_nxt = w_win ? S_OWN1 : S_OWN0;
      w_last_nxt  = w_win;
      if (w_same_owner) begin
        w_cnt_nxt = (r_burst_cnt >= C_MAX) ? C_MAX : r_burst_cnt + 4'd1;
      end else begin
        w_cnt_nxt = 4'd1;
      end
    end
  end

  assign w_win_we = w_win ? bus.m_we[1] : bus.m_we[0];
  // Reset masks the grant so nothing is accepted on a reset edge
  assign w_go     = w_win_vld & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_burst_cnt <= 4'd0;
      r_last_gnt  <= 1'b1;
      r_rd_pend   <= 1'b0;
      r_rd_id     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_cnt_nxt;
      r_last_gnt  <= w_last_nxt;
      r_rd_pend   <= w_win_vld & ~w_win_we;
      if (w_win_vld && !w_win_we) begin
        r_rd_id <= w_win;
      end
    end
  end

  always_comb begin
    bus.m_gnt    = 2'b00;
    bus.m_rvalid = 2'b00;
    sram_ceb     = 1'b1;
    sram_web     = 1'b1;
    sram_bweb    = '1;
    sram_a       = 14'd0;
    sram_di      = 32'd0;
    if (w_go) begin
      bus.m_gnt[w_win] = 1'b1;
      sram_ceb         = 1'b0;
      sram_web         = ~w_win_we;
      sram_a           = w_win ? bus.m1_addr  : bus.m0_addr;
      sram_di          = w_win ? bus.m1_wdata : bus.m0_wdata;
      if (w_win_we) begin
        sram_bweb = w_win ? bus.m1_bweb : bus.m0_bweb;
      end
    end
    if (r_rd_pend && !rst) begin
      bus.m_rvalid[r_rd_id] = 1'b1;
    end
  end

  assign bus.m_rdata = sram_do;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_sram_port_arbiter                                                     |
// | Directed stimulus with a per-cycle reference model of the arbiter.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sram_port_arbiter;
  localparam int MAX = 4;

  logic        clk;
  logic        rst;
  logic        sram_ceb;
  logic        sram_web;
  logic [31:0] sram_bweb;
  logic [13:0] sram_a;
  logic [31:0] sram_di;
  logic [31:0] sram_do;

  int checks = 0;
  int errors = 0;

  bit [31:0] sram_mem [16384];
  bit [31:0] ref_mem  [16384];

  sram_port_arbiter_if bus();

  sram_port_arbiter #(.MAX_BURST(MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .sram_ceb  (sram_ceb),
    .sram_web  (sram_web),
    .sram_bweb (sram_bweb),
    .sram_a    (sram_a),
    .sram_di   (sram_di),
    .sram_do   (sram_do)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM macro: 1-cycle read, bit-masked write
  always @(posedge clk) begin
    if (!sram_ceb) begin
      if (!sram_web) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_bweb) | (sram_di & ~sram_bweb);
      else           sram_do <= sram_mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/run-length view of the arbitration rules
  int        mo_owner = -1;
  int        mo_run   = 0;
  int        mo_last  = 1;
  bit        mo_pend  = 0;
  int        mo_pid   = 0;
  bit [31:0] mo_pdata = 0;

  always @(negedge clk) begin
    int        ew;
    int        oth;
    bit        r0, r1, wwe;
    logic [1:0]  egnt, erv;
    logic [13:0] ea;
    logic [31:0] edi, ebweb;
    r0 = bus.m_req[0];
    r1 = bus.m_req[1];
    ew = -1;
    if (!rst) begin
      if (mo_owner < 0) begin
        if (r0 && r1) ew = 1 - mo_last;
        else if (r0)  ew = 0;
        else if (r1)  ew = 1;
      end else begin
        oth = 1 - mo_owner;
        if (bus.m_req[mo_owner] && (mo_run < MAX || !bus.m_req[oth])) ew = mo_owner;
        else if (bus.m_req[oth]) ew = oth;
      end
    end
    egnt = (ew < 0) ? 2'b00 : 2'(1 << ew);
    erv  = (!rst && mo_pend) ? 2'(1 << mo_pid) : 2'b00;
    wwe  = (ew == 1) ? bus.m_we[1] : bus.m_we[0];
    ea   = 14'd0; edi = 32'd0; ebweb = 32'hFFFFFFFF;
    if (ew >= 0) begin
      ea  = (ew == 1) ? bus.m1_addr  : bus.m0_addr;
      edi = (ew == 1) ? bus.m1_wdata : bus.m0_wdata;
      if (wwe) ebweb = (ew == 1) ? bus.m1_bweb : bus.m0_bweb;
    end
    check("m_gnt", {30'd0, bus.m_gnt}, {30'd0, egnt});
    check("m_rvalid", {30'd0, bus.m_rvalid}, {30'd0, erv});
    if (erv != 2'b00) check("m_rdata", bus.m_rdata, mo_pdata);
    check("sram_ceb", {31'd0, sram_ceb}, {31'd0, (ew < 0)});
    check("sram_web", {31'd0, sram_web}, {31'd0, (ew < 0) || !wwe});
    check("sram_a", {18'd0, sram_a}, {18'd0, ea});
    check("sram_di", sram_di, edi);
    check("sram_bweb", sram_bweb, ebweb);

    if (rst) begin
      mo_owner = -1; mo_run = 0; mo_last = 1; mo_pend = 0;
    end else if (ew >= 0) begin
      mo_run   = (ew == mo_owner) ? ((mo_run + 1 > MAX) ? MAX : mo_run + 1) : 1;
      mo_owner = ew;
      mo_last  = ew;
      mo_pend  = !wwe;
      mo_pid   = ew;
      if (wwe) ref_mem[ea] = (ref_mem[ea] & ebweb) | (edi & ~ebweb);
      else     mo_pdata = ref_mem[ea];
    end else begin
      mo_owner = -1; mo_run = 0; mo_pend = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_none();
    bus.m_req = 2'b00;
    bus.m_we  = 2'b00;
  endtask

  logic [1:0] glog [12];
  logic [1:0] gexp [12];

  initial begin
    sram_do = 32'd0;
    sram_mem[14'h0010] = 32'hDEADBEEF; ref_mem[14'h0010] = 32'hDEADBEEF;
    sram_mem[14'h0020] = 32'hAAAAAAAA; ref_mem[14'h0020] = 32'hAAAAAAAA;
    rst = 1'b1;
    bus.m_req = 2'b11; bus.m_we = 2'b00;
    bus.m0_addr = 14'h0010; bus.m1_addr = 14'h0020;
    bus.m0_bweb = '1; bus.m1_bweb = '1;
    bus.m0_wdata = 32'd0; bus.m1_wdata = 32'd0;
    cyc(); cyc();
    #3;
    check("reset_gnt", {30'd0, bus.m_gnt}, 32'd0);
    check("reset_ceb", {31'd0, sram_ceb}, 32'd1);
    check("reset_bweb", sram_bweb, 32'hFFFFFFFF);
    cyc();
    rst = 1'b0;
    req_none();

    // Single read
    cyc();
    bus.m_req = 2'b01; bus.m0_addr = 14'h0010;
    #3 check("rd_gnt", {30'd0, bus.m_gnt}, 32'd1);
    cyc(); req_none();
    #3 check("rd_rvalid", {30'd0, bus.m_rvalid}, 32'd1);
    check("rd_data", bus.m_rdata, 32'hDEADBEEF);

    // Byte write then read back
    cyc();
    bus.m_req = 2'b10; bus.m_we = 2'b10; bus.m1_addr = 14'h0020;
    bus.m1_wdata = 32'h11223344; bus.m1_bweb = 32'hFFFFFF00;
    #3 check("wr_gnt", {30'd0, bus.m_gnt}, 32'd2);
    check("wr_web", {31'd0, sram_web}, 32'd0);
    cyc(); req_none();
    #3 check("wr_rvalid", {30'd0, bus.m_rvalid}, 32'd0);
    cyc();
    bus.m_req = 2'b10; bus.m_we = 2'b00;
    cyc(); req_none();
    #3 check("wr_readback", bus.m_rdata, 32'hAAAAAA44);
    check("wr_rb_rvalid", {30'd0, bus.m_rvalid}, 32'd2);

    // Contention from reset
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    gexp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
             2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 12; i++) begin
      bus.m_req = 2'b11; bus.m_we = 2'b00;
      bus.m0_addr = 14'(16 + i); bus.m1_addr = 14'(32 + i);
      #3 glog[i] = bus.m_gnt;
      cyc();
    end
    for (int i = 0; i < 12; i++) check($sformatf("contend_gnt%0d", i), {30'd0, glog[i]}, {30'd0, gexp[i]});

    // Idle pins
    req_none();
    cyc();
    #3 check("idle_ceb", {31'd0, sram_ceb}, 32'd1);
    check("idle_web", {31'd0, sram_web}, 32'd1);
    check("idle_bweb", sram_bweb, 32'hFFFFFFFF);
    check("idle_a", {18'd0, sram_a}, 32'd0);
    check("idle_gnt", {30'd0, bus.m_gnt}, 32'd0);

    // Saturation: M0 alone 10 cycles, then M1 arrives
    cyc();
    bus.m_req = 2'b01;
    repeat (10) cyc();
    bus.m_req = 2'b11;
    #3 check("sat_handover", {30'd0, bus.m_gnt}, 32'd2);
    cyc(); req_none();

    // Zero-bubble handover
    cyc();
    bus.m_req = 2'b01;
    cyc(); cyc();
    bus.m_req = 2'b10;
    #3 check("zero_bubble", {30'd0, bus.m_gnt}, 32'd2);
    cyc(); req_none();

    // Reset mid-read
    cyc();
    bus.m_req = 2'b01; bus.m0_addr = 14'h0010;
    cyc();
    rst = 1'b1; req_none();
    #3 check("rst_midread_rv", {30'd0, bus.m_rvalid}, 32'd0);
    cyc();
    rst = 1'b0; bus.m_req = 2'b11;
    #3 check("post_rst_tie", {30'd0, bus.m_gnt}, 32'd1);
    cyc(); req_none();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-master arbiter that shares one SRAM_wrapper macro (14-bit word address, 32-bit data, 1-cycle read latency) between an instruction-fetch port (M0) and a data-access port (M1). It sits between the CPU memory ports and a single SRAM_wrapper instance. This lets the core run from one unified array instead of separate IM and DM macros. It applies round-robin arbitration with a bounded burst length, drives the SRAM control pins, and routes read data back with a registered valid.

## Interface
- MAX_BURST, 4: max consecutive grants to one master while the other is requesting; legal range 1..15
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- m_req  in  2  per-master request; bit0 = M0 (fetch), bit1 = M1 (data)
- m_we  in  2  per-master write flag; 1 = write, 0 = read
- m0_addr / m1_addr  in  14  word address
- m0_bweb / m1_bweb  in  32  bit write enable, active-low, used only on writes
- m0_wdata / m1_wdata  in  32  write data
- m_gnt  out  2  one-hot or zero; a request is accepted on the edge where req&gnt=1
- m_rvalid  out  2  read data valid for that master, one cycle after the accepted read
- m_rdata  out  32  shared read data for both masters; equals sram_do
- sram_ceb  out  1  chip enable, active-low
- sram_web  out  1  0 = write, 1 = read
- sram_bweb  out  32  bit write enable, active-low
- sram_a  out  14  address
- sram_di  out  32  write data
- sram_do  in  32  SRAM read data, valid the cycle after a read is accepted

## Operation
- FSM states:
  - IDLE
  - OWN0
  - OWN1
- burst_cnt: 4-bit consecutive-grant counter.
- last_gnt: 1-bit, identifies the last master granted.
- Winner selection (combinational, from state and m_req):
  - IDLE:
    - If both masters request, the master != last_gnt wins.
    - Otherwise the single requester wins.
  - OWNx:
    - x wins if req_x and (burst_cnt < MAX_BURST or !req_other).
    - Else the other master wins if it is requesting.
    - Else no winner.
- On the edge, if there is a winner:
  - State becomes OWN<winner> and last_gnt becomes winner.
  - If winner == current owner, burst_cnt = min(burst_cnt+1, MAX_BURST); otherwise burst_cnt = 1.
- On the edge, if there is no winner: IDLE, burst_cnt = 0, last_gnt unchanged.
- SRAM pins when there is a winner: ceb=0, web=~we_w, a/bweb/di from the winner.
- Reads force sram_bweb to all ones.
- SRAM pins when there is no winner: ceb=1, web=1, bweb=all ones, a=0, di=0.
- Writes are posted and produce no response. Acceptance is completion.
- Read return uses two registers:
  - rd_pend_q is set on an accepted read; rd_id_q holds the winner.
  - m_rvalid[rd_id_q] = rd_pend_q; the other bit is 0.
- Back-to-back reads are allowed every cycle. There is at most one read in flight per cycle, so no queueing is needed.
- Requester rules:
  - Hold req/we/addr/bweb/wdata stable until gnt is seen high.
  - req must not depend combinationally on gnt.

## Timing
- Reset values of registered state: IDLE, burst_cnt=0, last_gnt=1 (so M0 wins the first tie), rd_pend_q=0, rd_id_q=0.
- Reset values of outputs while rst=1:
  - m_gnt=0 and m_rvalid=0, forced regardless of req.
  - sram_ceb=1, sram_web=1, sram_bweb=all ones, sram_a=0, sram_di=0.
- Grant latency: 0 cycles. gnt is combinational in the cycle req is high, and the SRAM captures on that same edge.
- Read latency: m_rvalid and m_rdata are valid exactly 1 cycle after the accepting edge.
- Zero-bubble handover: if the owner drops req in the same cycle the other master requests, the other master is granted that cycle.
- Burst limit:
  - Under continuous contention, the sequence is MAX_BURST grants to one master, then MAX_BURST to the other, repeating.
  - With MAX_BURST=1 the grants strictly alternate.
  - With a sole requester, burst_cnt saturates at MAX_BURST. A newly arriving other master is then granted on its first cycle.
- Reset mid-read: rd_pend_q clears. No rvalid is issued after reset for a read accepted before reset.

## Test plan
- Single read:
  - Preload addr 0x0010=0xDEADBEEF.
  - M0 reads 0x0010 → gnt=01 in the same cycle; next cycle m_rvalid=01, m_rdata=0xDEADBEEF.
- Byte write:
  - M1 writes 0x0020, wdata=0x11223344, bweb=0xFFFFFF00.
  - Location previously held 0xAAAAAAAA → a later read returns 0xAAAAAA44.
  - m_rvalid stays 00 for the write.
- Contention from reset:
  - Both masters hold req for 12 cycles, MAX_BURST=4.
  - Required grant sequence: M0×4, M1×4, M0×4.
  - m_rvalid tracks each read one cycle later with the correct id.
- Handover and saturation:
  - M0 streams alone for 10 cycles; M1 then requests → M1 granted on its first cycle.
  - In a separate scenario, M0 drops req in the same cycle M1 raises it → M1 granted with no idle cycle.
- Idle pins: with no requests, sram_ceb=1, sram_web=1, sram_bweb=0xFFFFFFFF, sram_a=0, and m_gnt=00.
- Reset mid-read:
  - rst=1 is asserted on the cycle after an M0 read is accepted → m_rvalid=00 in that cycle.
  - After rst is released, the first tie goes to M0.
